// File: rtl/sid_envelope_gen_pkg.sv
// sid_env_pkg: shared types and constants for the SID ADSR envelope generator.
//   env_state_t  : ADSR state encoding (ATTACK, DECAY_SUSTAIN, RELEASE)
//   RATE_PERIOD  : rate-counter period per 4-bit rate nibble
//   exp_period() : exponential-counter period latched at envelope breakpoints
package sid_env_pkg;
   localparam int RATE_BITS = 15;
   localparam int EXP_BITS  = 5;
   typedef enum logic [1:0] {ATTACK, DECAY_SUSTAIN, RELEASE} env_state_t;
   localparam logic [RATE_BITS-1:0] RATE_PERIOD [16] = '{
      15'd9, 15'd32, 15'd63, 15'd95, 15'd149, 15'd220, 15'd267, 15'd313,
      15'd392, 15'd977, 15'd1954, 15'd3126, 15'd3907, 15'd11720, 15'd19532, 15'd31251};
   localparam logic [7:0] EXP_BP_1  = 8'hFF;
   localparam logic [7:0] EXP_BP_2  = 8'h5D;
   localparam logic [7:0] EXP_BP_4  = 8'h36;
   localparam logic [7:0] EXP_BP_8  = 8'h1A;
   localparam logic [7:0] EXP_BP_16 = 8'h0E;
   localparam logic [7:0] EXP_BP_30 = 8'h06;
   // Period only changes when the envelope lands exactly on a breakpoint,
   // in either direction; otherwise the last latched value is kept.
   function automatic logic [EXP_BITS-1:0] exp_period(input logic [7:0] env, input logic [EXP_BITS-1:0] cur);
      return (env == EXP_BP_1 || env == 8'h00) ? 5'd1  :
             (env == EXP_BP_2)                 ? 5'd2  :
             (env == EXP_BP_4)                 ? 5'd4  :
             (env == EXP_BP_8)                 ? 5'd8  :
             (env == EXP_BP_16)                ? 5'd16 :
             (env == EXP_BP_30)                ? 5'd30 : cur;
   endfunction
endpackage

// File: rtl/sid_envelope_gen_if.sv
// sid_envelope_gen_if: per-voice envelope control/status bundle.
//   phi2_en, gate, attack, decay, sustain, rel : driven by the voice registers (master)
//   env_out, state_out                         : driven by the envelope generator (slave)
interface sid_envelope_gen_if;
   import sid_env_pkg::*;
   logic       phi2_en;
   logic       gate;
   logic [3:0] attack;
   logic [3:0] decay;
   logic [3:0] sustain;
   logic [3:0] rel;
   logic [7:0] env_out;
   env_state_t state_out;
   modport master (output phi2_en, gate, attack, decay, sustain, rel, input env_out, state_out);
   modport slave  (input phi2_en, gate, attack, decay, sustain, rel, output env_out, state_out);
endinterface

// File: rtl/sid_env_rate_cnt.sv
// sid_env_rate_cnt: 15-bit rate counter with per-state period select; pulses step on period match.
//   clk, rst  : clock, async active-high reset
//   phi2_en   : SID cycle tick
//   state     : current (pre-gate-edge) ADSR state, selects the rate nibble
//   attack, decay, rel : rate nibbles
//   step      : rate step fires on this tick
// Macro SID_ENV_ADSR_BUG_EN: equality-only compare, counter wraps when the period drops below it.
module sid_env_rate_cnt
   import sid_env_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       phi2_en,
   input  env_state_t state,
   input  logic [3:0] attack,
   input  logic [3:0] decay,
   input  logic [3:0] rel,
   output logic       step
);
   logic [RATE_BITS-1:0] cnt, cnt_inc, period;
   assign period  = RATE_PERIOD[state == ATTACK ? attack : state == DECAY_SUSTAIN ? decay : rel];
   assign cnt_inc = cnt + 15'd1;
`ifdef SID_ENV_ADSR_BUG_EN
   assign step = phi2_en && (cnt_inc == period);
`else
   assign step = phi2_en && (cnt_inc >= period);
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (phi2_en) cnt <= step ? '0 : cnt_inc;
endmodule

// File: rtl/sid_envelope_gen.sv
// sid_envelope_gen: per-voice SID ADSR envelope generator feeding the 8-bit envelope DAC.
//   clk, rst : clock, async active-high reset
//   bus      : sid_envelope_gen_if.slave (phi2_en, gate, attack, decay, sustain, rel in;
//              env_out, state_out out, both registered)
// Macro SID_ENV_ADSR_BUG_EN (in sid_env_rate_cnt) selects the real-chip rate-counter wrap bug.
module sid_envelope_gen
   import sid_env_pkg::*;
(
   input logic clk,
   input logic rst,
   sid_envelope_gen_if.slave bus
);
   env_state_t          state, state_n;
   logic [7:0]          env, env_n;
   logic [EXP_BITS-1:0] exp_cnt, exp_cnt_n, exp_per, exp_per_n;
   logic                hold_zero, hold_zero_n, gate_q, step;

   // Period is chosen from the state held before this tick's gate edge.
   sid_env_rate_cnt u_rate (
      .clk(clk), .rst(rst), .phi2_en(bus.phi2_en), .state(state),
      .attack(bus.attack), .decay(bus.decay), .rel(bus.rel), .step(step));

   always_comb begin
      state_n     = state;
      env_n       = env;
      exp_cnt_n   = exp_cnt;
      exp_per_n   = exp_per;
      hold_zero_n = hold_zero;
      if (bus.gate && !gate_q) begin
         state_n     = ATTACK;
         hold_zero_n = 1'b0;
      end else if (!bus.gate && gate_q) state_n = RELEASE;
      if (step) begin
         if (state_n == ATTACK) begin
            exp_cnt_n = '0;
            env_n     = (env == 8'hFF) ? env : env + 8'd1;
            if (env_n == 8'hFF) state_n = DECAY_SUSTAIN;
         end else if (exp_cnt + 5'd1 == exp_per) begin
            exp_cnt_n = '0;
            if (!hold_zero && env != 8'h00 && !(state_n == DECAY_SUSTAIN && env == {bus.sustain, bus.sustain}))
               env_n = env - 8'd1;
         end else exp_cnt_n = exp_cnt + 5'd1;
      end
      if (env_n != env) begin
         exp_per_n = exp_period(env_n, exp_per);
         if (env_n == 8'h00) hold_zero_n = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= RELEASE;
         env       <= '0;
         exp_cnt   <= '0;
         exp_per   <= 5'd1;
         hold_zero <= 1'b1;
         gate_q    <= 1'b0;
      end else if (bus.phi2_en) begin
         state     <= state_n;
         env       <= env_n;
         exp_cnt   <= exp_cnt_n;
         exp_per   <= exp_per_n;
         hold_zero <= hold_zero_n;
         gate_q    <= bus.gate;
      end

   assign bus.env_out   = env;
   assign bus.state_out = state;
endmodule

// File: tb/tb_sid_envelope_gen.sv
// tb_sid_envelope_gen: directed ADSR scenarios plus randomized traffic against a tick-level reference model.
module tb_sid_envelope_gen;
   logic clk = 1'b0;
   logic rst;
   sid_envelope_gen_if bus();
   sid_envelope_gen dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int m_env, m_state, m_rate, m_exp, m_per, m_hz, m_gq;
   int tab [16] = '{9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907, 11720, 19532, 31251};
   int used;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_env = 0; m_state = 2; m_rate = 0; m_exp = 0; m_per = 1; m_hz = 1; m_gq = 0;
   endtask

   function automatic int exp_lookup(input int e, input int cur);
      case (e)
         255, 0: return 1;
         93:     return 2;
         54:     return 4;
         26:     return 8;
         14:     return 16;
         6:      return 30;
         default: return cur;
      endcase
   endfunction

   // One SID cycle of the envelope, straight from the behavioural rules.
   task automatic model_step();
      int per, ns, r, old;
      bit fire;
      per = tab[m_state == 0 ? bus.attack : m_state == 1 ? bus.decay : bus.rel];
      ns = m_state;
      if (bus.gate && !m_gq) begin ns = 0; m_hz = 0; end
      else if (!bus.gate && m_gq) ns = 2;
      m_gq = bus.gate;
      r = (m_rate + 1) % 32768;
`ifdef SID_ENV_ADSR_BUG_EN
      fire = (r == per);
`else
      fire = (r >= per);
`endif
      m_rate = fire ? 0 : r;
      old = m_env;
      if (fire) begin
         if (ns == 0) begin
            m_exp = 0;
            if (m_env < 255) m_env++;
            if (m_env == 255) ns = 1;
         end else if (m_exp + 1 == m_per) begin
            m_exp = 0;
            if (m_hz == 0 && m_env > 0 && !(ns == 1 && m_env == bus.sustain * 17)) m_env--;
         end else m_exp++;
      end
      if (m_env != old) begin
         m_per = exp_lookup(m_env, m_per);
         if (m_env == 0) m_hz = 1;
      end
      m_state = ns;
   endtask

   task automatic tick(input bit en);
      bus.phi2_en = en;
      @(posedge clk);
      if (en) model_step();
      #1;
      chk("env", int'(bus.env_out), m_env);
      chk("state", int'(bus.state_out), m_state);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick(1'b1);
   endtask

   task automatic run_until(input string tag, input int target, input int budget, output int n);
      n = 0;
      while (int'(bus.env_out) != target && n < budget) begin tick(1'b1); n++; end
      chk(tag, int'(bus.env_out), target);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.phi2_en = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.gate = 1'b0; bus.attack = 4'd0; bus.decay = 4'd0; bus.sustain = 4'hA; bus.rel = 4'd0;
      do_reset();
      chk("rst_env", int'(bus.env_out), 0);
      chk("rst_state", int'(bus.state_out), 2);

      // 1: attack=0 -> first step after 9 ticks, full scale after 2295
      bus.gate = 1'b1;
      ticks(8);
      chk("t1_before", int'(bus.env_out), 0);
      tick(1'b1);
      chk("t1_first", int'(bus.env_out), 1);
      ticks(2286);
      chk("t1_full", int'(bus.env_out), 255);
      chk("t1_ds", int'(bus.state_out), 1);

      // 2: decay=0 down to sustain 0xAA, then hold
      ticks(765);
      chk("t2_sus", int'(bus.env_out), 8'hAA);
      ticks(2000);
      chk("t2_hold", int'(bus.env_out), 8'hAA);

      // 3: release through the exponential breakpoints
      bus.gate = 1'b0;
      run_until("t3_5d", 8'h5D, 2000, used);
      run_until("t3_36", 8'h36, 2000, used);
      chk("t3_per2", used, 39 * 2 * 9);
      run_until("t3_1a", 8'h1A, 2000, used);
      chk("t3_per4", used, 28 * 4 * 9);
      run_until("t3_0e", 8'h0E, 2000, used);
      chk("t3_per8", used, 12 * 8 * 9);
      run_until("t3_06", 8'h06, 2000, used);
      chk("t3_per16", used, 8 * 16 * 9);
      run_until("t3_00", 8'h00, 3000, used);
      chk("t3_per30", used, 6 * 30 * 9);
      ticks(5000);
      chk("t3_zero_hold", int'(bus.env_out), 0);
      chk("t3_rel", int'(bus.state_out), 2);

      // 4: re-attack from the middle of a release
      bus.gate = 1'b1;
      run_until("t4_up40", 8'h40, 1000, used);
      bus.gate = 1'b0;
      ticks(10);
      chk("t4_rel40", int'(bus.env_out), 8'h40);
      chk("t4_relst", int'(bus.state_out), 2);
      bus.gate = 1'b1;
      run_until("t4_41", 8'h41, 20, used);
      chk("t4_att", int'(bus.state_out), 0);

      // 5: lower the release period below the running count
      run_until("t5_ff", 8'hFF, 2000, used);
      bus.gate = 1'b0; bus.rel = 4'hF; bus.decay = 4'hF;
      ticks(100);
      bus.rel = 4'd0;
`ifdef SID_ENV_ADSR_BUG_EN
      ticks(32676);
      chk("t5_wait", int'(bus.env_out), 8'hFF);
      tick(1'b1);
      chk("t5_step", int'(bus.env_out), 8'hFE);
`else
      chk("t5_wait", int'(bus.env_out), 8'hFF);
      tick(1'b1);
      chk("t5_step", int'(bus.env_out), 8'hFE);
`endif

      // randomized traffic
      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(0, 399) == 0) bus.gate = ~bus.gate;
         if ($urandom_range(0, 199) == 0) bus.attack  = 4'($urandom_range(0, 2));
         if ($urandom_range(0, 199) == 0) bus.decay   = 4'($urandom_range(0, 2));
         if ($urandom_range(0, 199) == 0) bus.rel     = 4'($urandom_range(0, 2));
         if ($urandom_range(0, 299) == 0) bus.sustain = 4'($urandom_range(0, 15));
         tick($urandom_range(0, 3) != 0);
      end

      // 6: asynchronous reset mid-attack while phi2_en is low
      do_reset();
      bus.attack = 4'd0;
      bus.gate = 1'b1;
      ticks(50);
      chk("t6_pre_env", int'(bus.env_out), 5);
      chk("t6_pre_st", int'(bus.state_out), 0);
      bus.phi2_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_async_env", int'(bus.env_out), 0);
      chk("t6_async_st", int'(bus.state_out), 2);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      ticks(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
